// File: rtl/trilat_calc_pkg.sv
// Shared widths, FSM encoding and divider iteration count for the
// trilateration front stage of the position-detector datapath.
package trilat_calc_pkg;

  localparam int DIST_W   = 12;
  localparam int Y2_W     = 32;
  localparam int DIV_ITER = 25;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SQUARE = 2'd1,
    DIVIDE = 2'd2,
    YCALC  = 2'd3
  } state_t;

endpackage

// File: rtl/trilat_calc_seq_divider.sv
// Restoring unsigned divider: one quotient bit per clock, DVD_W iterations.
// done is high during the cycle whose closing edge writes the last quotient bit.
module seq_divider
  import trilat_calc_pkg::*;
#(
  parameter int DVD_W = DIV_ITER,
  parameter int DVS_W = DIST_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [DVD_W-1:0] quotient
);

  localparam int CNT_W = $clog2(DVD_W);

  logic [CNT_W-1:0] cnt;
  logic [DVS_W-1:0] rem_p0;
  logic [DVS_W-1:0] dvs_p0;
  logic [DVS_W:0]   trial;
  logic [DVS_W:0]   diff;

  always_comb begin
    trial = {rem_p0, quotient[DVD_W-1]};
    diff  = trial - {1'b0, dvs_p0};
  end

  assign done = busy && (cnt == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (start && !busy) begin
      busy <= 1'b1;
      cnt  <= CNT_W'(DVD_W - 1);
    end else if (busy) begin
      if (cnt == '0) busy <= 1'b0;
      else           cnt  <= cnt - 1'b1;
    end
  end

  // Quotient shares the dividend shift register; remainder never exceeds divisor.
  always_ff @(posedge clk) begin
    if (start && !busy) begin
      quotient <= dividend;
      rem_p0   <= '0;
      dvs_p0   <= divisor;
    end else if (busy) begin
      if (trial >= {1'b0, dvs_p0}) begin
        rem_p0   <= diff[DVS_W-1:0];
        quotient <= {quotient[DVD_W-2:0], 1'b1};
      end else begin
        rem_p0   <= trial[DVS_W-1:0];
        quotient <= {quotient[DVD_W-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/trilat_calc.sv
// Two-sensor trilateration: x = (d1^2 - d2^2 + L^2) / 2L, y^2 = d1^2 - x^2,
// clamped and handed to the square-root stage with a one-cycle strobe.
module trilat_calc #(
  parameter int SENSOR_SPACING = 100,
  parameter int DIST_W         = 12
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [DIST_W-1:0]                dist1,
  input  logic [DIST_W-1:0]                dist2,
  input  logic                             dist_valid,
  output logic                             dist_ready,
  output logic [DIST_W-1:0]                xValue,
  output logic [trilat_calc_pkg::Y2_W-1:0] y1Value,
  output logic                             out_valid,
  output logic                             out_of_range
);
  import trilat_calc_pkg::*;

  localparam int SQ_W    = 2 * DIST_W;
  localparam int NUM_W   = SQ_W + 2;
  localparam int L_SQ    = SENSOR_SPACING * SENSOR_SPACING;
  localparam int XMAX    = (1 << DIST_W) - 1;

  function automatic logic [DIST_W-1:0] sat_x(input logic [DIV_ITER-1:0] q);
    return (q > DIV_ITER'(XMAX)) ? DIST_W'(XMAX) : q[DIST_W-1:0];
  endfunction

  function automatic logic [Y2_W-1:0] sat_y(input logic signed [NUM_W-1:0] v);
    return (v < 0) ? '0 : {{(Y2_W-NUM_W){1'b0}}, v};
  endfunction

  state_t st;

  logic [DIST_W-1:0]       d1_p0, d2_p0;
  logic [SQ_W-1:0]         sq1_p1;
  logic                    neg_p1;
  logic [SQ_W-1:0]         sq1_c, sq2_c, xsq_c;
  logic signed [NUM_W-1:0] num_c, y_c;
  logic [DIV_ITER-1:0]     dvd_c, quo;
  logic [DIST_W-1:0]       x_c;
  logic                    xclamp_c;
  logic                    div_busy, div_done;

  always_comb begin
    sq1_c    = SQ_W'(d1_p0) * SQ_W'(d1_p0);
    sq2_c    = SQ_W'(d2_p0) * SQ_W'(d2_p0);
    num_c    = $signed({2'b00, sq1_c}) + NUM_W'(L_SQ) - $signed({2'b00, sq2_c});
    dvd_c    = num_c[NUM_W-1] ? '0 : num_c[DIV_ITER-1:0];
    x_c      = sat_x(quo);
    xclamp_c = |quo[DIV_ITER-1:DIST_W];
    xsq_c    = SQ_W'(x_c) * SQ_W'(x_c);
    y_c      = $signed({2'b00, sq1_p1}) - $signed({2'b00, xsq_c});
  end

  seq_divider #(
    .DVD_W (DIV_ITER),
    .DVS_W (DIST_W)
  ) u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (st == SQUARE),
    .dividend (dvd_c),
    .divisor  (DIST_W'(2 * SENSOR_SPACING)),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (quo)
  );

  // Operand capture (IDLE accept) and square stage; data regs carry no reset.
  always_ff @(posedge clk) begin
    if (st == IDLE && dist_valid) begin
      d1_p0 <= dist1;
      d2_p0 <= dist2;
    end
    if (st == SQUARE) begin
      sq1_p1 <= sq1_c;
      neg_p1 <= num_c[NUM_W-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st           <= IDLE;
      dist_ready   <= 1'b1;
      xValue       <= '0;
      y1Value      <= '0;
      out_valid    <= 1'b0;
      out_of_range <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (st)
        IDLE: begin
          if (dist_valid) begin
            st         <= SQUARE;
            dist_ready <= 1'b0;
          end
        end
        SQUARE: st <= DIVIDE;
        DIVIDE: begin
          if (div_done)       st <= YCALC;
          else if (!div_busy) st <= SQUARE;
        end
        YCALC: begin
          xValue       <= x_c;
          y1Value      <= sat_y(y_c);
          out_of_range <= neg_p1 | xclamp_c | (y_c < 0);
          out_valid    <= 1'b1;
          dist_ready   <= 1'b1;
          st           <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trilat_calc.sv
// Randomized and directed bench for trilat_calc against an integer-arithmetic
// model of the trilateration formulas.
module tb_trilat_calc;

  localparam int L = 100;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] dist1, dist2;
  logic        dist_valid;
  logic        dist_ready;
  logic [11:0] xValue;
  logic [31:0] y1Value;
  logic        out_valid;
  logic        out_of_range;

  int checks = 0;
  int errors = 0;

  trilat_calc #(.SENSOR_SPACING(L), .DIST_W(12)) dut (
    .clk          (clk),
    .reset        (reset),
    .dist1        (dist1),
    .dist2        (dist2),
    .dist_valid   (dist_valid),
    .dist_ready   (dist_ready),
    .xValue       (xValue),
    .y1Value      (y1Value),
    .out_valid    (out_valid),
    .out_of_range (out_of_range)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model(input int a, input int b,
                                output longint x, output longint y, output bit oor);
    longint num;
    num = longint'(a) * a + longint'(L) * L - longint'(b) * b;
    oor = (num < 0);
    x   = oor ? 0 : num / (2 * L);
    if (x > 4095) begin x = 4095; oor = 1; end
    y = longint'(a) * a - x * x;
    if (y < 0) begin y = 0; oor = 1; end
  endfunction

  task automatic do_pair(input int a, input int b);
    int cyc;
    bit seen, rdy_bad;
    longint ex, ey;
    bit eo;
    logic [11:0] hx;
    string t;
    t = $sformatf("(%0d,%0d)", a, b);
    @(negedge clk);
    dist1 = 12'(a); dist2 = 12'(b); dist_valid = 1'b1;
    chk({"ready_idle", t}, dist_ready, 1);
    @(posedge clk);
    #1 dist_valid = 1'b0;
    dist1 = 12'($urandom); dist2 = 12'($urandom);
    cyc = 0; seen = 0; rdy_bad = 0;
    while (!seen && cyc < 40) begin
      @(posedge clk); cyc++;
      #1;
      if (out_valid) seen = 1;
      else if (dist_ready) rdy_bad = 1;
    end
    model(a, b, ex, ey, eo);
    chk({"latency", t}, cyc, 27);
    chk({"ready_busy", t}, rdy_bad, 0);
    chk({"x", t}, xValue, ex);
    chk({"y", t}, y1Value, ey);
    chk({"oor", t}, out_of_range, eo);
    chk({"ready_at_valid", t}, dist_ready, 1);
    hx = xValue;
    @(posedge clk); #1;
    chk({"pulse_low", t}, out_valid, 0);
    chk({"x_hold", t}, xValue, hx);
  endtask

  initial begin
    int cyc, nres, cnt;
    bit rdy_bad;
    longint ex, ey;
    bit eo;

    reset = 1'b1; dist_valid = 1'b0; dist1 = '0; dist2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_ready", dist_ready, 1);
    chk("rst_x", xValue, 0);
    chk("rst_y", y1Value, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_oor", out_of_range, 0);

    do_pair(100, 100);
    do_pair(130, 100);
    do_pair(50, 150);
    do_pair(0, 0);
    do_pair(4095, 0);
    do_pair(4095, 4095);
    do_pair(0, 4095);

    // Back-to-back with dist_valid held high
    @(negedge clk);
    dist1 = 12'd100; dist2 = 12'd100; dist_valid = 1'b1;
    @(posedge clk);
    #1 dist1 = 12'd130; dist2 = 12'd100;
    cyc = 0; nres = 0; rdy_bad = 0;
    while (nres < 2 && cyc < 80) begin
      @(posedge clk); cyc++;
      #1;
      if (out_valid) begin
        nres++;
        model((nres == 1) ? 100 : 130, 100, ex, ey, eo);
        chk("b2b_lat", cyc, (nres == 1) ? 27 : 55);
        chk("b2b_x", xValue, ex);
        chk("b2b_y", y1Value, ey);
        chk("b2b_oor", out_of_range, eo);
        if (nres == 2) dist_valid = 1'b0;
      end else if (dist_ready) rdy_bad = 1;
    end
    chk("b2b_count", nres, 2);
    chk("b2b_ready_busy", rdy_bad, 0);
    dist_valid = 1'b0;
    @(posedge clk); #1;

    // Reset in the middle of the division
    @(negedge clk);
    dist1 = 12'd130; dist2 = 12'd100; dist_valid = 1'b1;
    @(posedge clk);
    #1 dist_valid = 1'b0;
    repeat (11) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_x", xValue, 0);
    chk("abort_y", y1Value, 0);
    chk("abort_valid", out_valid, 0);
    chk("abort_oor", out_of_range, 0);
    chk("abort_ready", dist_ready, 1);
    @(negedge clk) reset = 1'b0;
    cnt = 0;
    repeat (35) begin
      @(posedge clk); #1;
      if (out_valid) cnt++;
    end
    chk("abort_no_valid", cnt, 0);
    do_pair(100, 100);

    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) do_pair(int'($urandom_range(0, 300)), int'($urandom_range(0, 300)));
      else            do_pair(int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
